alu_op_sequencer: RTL

Nibble-serial front end and result stage for the 4-bit combinational ALU. Accepts a stream of 4-bit beats (opcode, then operands) over a valid/ready handshake, registers the operands and the 3-bit select, and drives the ALU. One cycle later it captures the ALU result and presents it on a valid/ready output port. An optional chaining flag reuses the previous result as operand A, so accumulator-style sequences need no extra beat.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_op_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU front end: opcode values,
// sequencer state encoding and the position of the chain flag in an opcode beat.
package alu_pkg;

  // Opcode values as driven on alu_sel.
  localparam logic [2:0] OP_NEGA = 3'b000;  // -A
  localparam logic [2:0] OP_NEGB = 3'b001;  // -B
  localparam logic [2:0] OP_ADD  = 3'b010;  // A + B
  localparam logic [2:0] OP_SUB  = 3'b011;  // A - B
  localparam logic [2:0] OP_MUL  = 3'b100;  // A * B, low nibble
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  // Bit of the opcode beat that requests reuse of the previous result as A.
  localparam int CHAIN_BIT = 3;

  typedef enum logic [2:0] {
    ST_GET_OP = 3'd0,
    ST_GET_A  = 3'd1,
    ST_GET_B  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/alu_op_sequencer.sv
// Front end and result stage for the 4-bit combinational ALU. Collects an
// opcode beat and up to two operand beats, holds them steady on the alu_*
// outputs for one EXEC cycle, captures the ALU result and offers it on a
// valid/ready port. A chained opcode reuses the last result as operand A.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [3:0]       alu_res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_data,
  output logic [2:0]       res_op,
  output logic [CNT_W-1:0] op_count
);

  state_t           r_state;
  logic             r_in_ready;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [2:0]       r_sel;
  logic             r_res_valid;
  logic [3:0]       r_res_data;
  logic [2:0]       r_res_op;
  logic [3:0]       r_last_res;
  logic [CNT_W-1:0] r_op_count;

  logic             w_transfer;
  logic [2:0]       w_op;
  logic             w_chain;

  // Beat handshake and opcode-beat field decode.
  assign w_transfer = in_valid && r_in_ready;
  assign w_op       = in_data[2:0];
  assign w_chain    = in_data[CHAIN_BIT];

  // Sequencer FSM with all outputs registered. in_ready is kept as its own
  // flop, loaded alongside every state change, so it is a clean state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_GET_OP;
      r_in_ready  <= 1'b1;
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= '0;
      r_last_res  <= '0;
      r_op_count  <= '0;
    end else begin
      // NOTE: every state register here uses <= so all flops sample the
      // pre-edge values; a blocking = would let later lines see updated state.
      case (r_state)
        ST_GET_OP: begin
          if (w_transfer) begin
            r_sel <= w_op;
            r_a   <= '0;
            r_b   <= '0;
            if (w_op == OP_NEGB) begin
              // A is unused, so the chain flag has nothing to do.
              r_state <= ST_GET_B;
            end else if (w_chain) begin
              r_a <= r_last_res;
              if (w_op == OP_NEGA) begin
                r_state    <= ST_EXEC;
                r_in_ready <= 1'b0;
              end else begin
                r_state <= ST_GET_B;
              end
            end else begin
              r_state <= ST_GET_A;
            end
          end
        end

        ST_GET_A: begin
          if (w_transfer) begin
            r_a <= in_data;
            if (r_sel == OP_NEGA) begin
              r_state    <= ST_EXEC;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= ST_GET_B;
            end
          end
        end

        ST_GET_B: begin
          if (w_transfer) begin
            r_b        <= in_data;
            r_state    <= ST_EXEC;
            r_in_ready <= 1'b0;
          end
        end

        ST_EXEC: begin
          // Operands were stable for the whole cycle; take the ALU output.
          r_res_data  <= alu_res;
          r_res_op    <= r_sel;
          r_last_res  <= alu_res;
          r_res_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end

        ST_HOLD: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_op_count  <= r_op_count + CNT_W'(1);
            r_state     <= ST_GET_OP;
            r_in_ready  <= 1'b1;
          end
        end

        // NOTE: the 3-bit state has unused codes; the default branch steers
        // them back to idle and keeps the case full so no hold logic is implied.
        default: begin
          r_state     <= ST_GET_OP;
          r_in_ready  <= 1'b1;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_sel   = r_sel;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_op    = r_res_op;
  assign op_count  = r_op_count;

endmodule
